pdn_power_sequencer: RTL

Digital power-up/power-down sequencer placed directly upstream of the six block6 power-consumer instances on the two shared multi-input supply nets (group A: blocks 0–2, group B: blocks 3–5). It requests each supply rail, waits for its power-good, and enables consumer blocks one at a time with a programmable stagger to bound inrush current. Power-down runs in reverse order. Supply loss or power-good timeout forces a fault shutdown.

---
 rtl/pdn_seq_pkg.sv | 35 +++
 rtl/pdn_sync2.sv | 22 ++
 rtl/pdn_power_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pdn_seq_pkg.sv
// pdn_power_sequencer shared types and constants.
// States, block counts and group boundaries.
package pdn_seq_pkg;

  localparam int NUM_BLK     = 6;
  localparam int BLK_PER_GRP = 3;

  localparam logic [2:0] GRP_A_FIRST = 3'd0;
  localparam logic [2:0] GRP_A_LAST  = 3'(BLK_PER_GRP - 1);
  localparam logic [2:0] GRP_B_FIRST = 3'(BLK_PER_GRP);
  localparam logic [2:0] GRP_B_LAST  = 3'(NUM_BLK - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT_PG_A,
    S_RAMP_A,
    S_WAIT_PG_B,
    S_RAMP_B,
    S_ON,
    S_RAMP_DOWN,
    S_FAULT
  } pdn_seq_state_t;

  // index of the highest set enable, 0 when none
  function automatic logic [2:0] hi_bit(
    input logic [NUM_BLK-1:0] v
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < NUM_BLK; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/pdn_sync2.sv
// pdn_sync2: two-flop synchronizer for
// an asynchronous power-good input.
module pdn_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= 1'b0;
      q <= 1'b0;
    end else begin
      m <= d;
      q <= m;
    end
  end

endmodule

// File: rtl/pdn_power_sequencer.sv
// pdn_power_sequencer: staggered power-up/down
// of two supply groups with fault shutdown.
module pdn_power_sequencer
  import pdn_seq_pkg::*;
#(
  parameter int STAGGER    = 8,
  parameter int PG_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_req,
  input  logic               pg_a,
  input  logic               pg_b,
  output logic               sup_en_a,
  output logic               sup_en_b,
  output logic [NUM_BLK-1:0] blk_en,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_fault
);

  localparam int SW = $clog2(STAGGER + 1);
  localparam int TW = $clog2(PG_TIMEOUT + 1);

  localparam logic [SW-1:0] S_LAST = SW'(STAGGER - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STAGGER);
  localparam logic [TW-1:0] T_LAST = TW'(PG_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(PG_TIMEOUT);

  pdn_seq_state_t state, state_d;

  logic [NUM_BLK-1:0] blk_d;
  logic               sua_d, sub_d;
  logic [SW-1:0]      scnt, scnt_d, scnt_inc;
  logic [TW-1:0]      tcnt, tcnt_d, tcnt_inc;
  logic               busy_d, done_d, fault_d;
  logic               pga_s, pgb_s;

  logic               step, lose, tmo, can_down;
  logic [2:0]         hb;
  logic [NUM_BLK-1:0] dn_blk;
  logic               dn_sua, dn_sub;

  pdn_sync2 u_sync_a (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pg_a),
    .q    (pga_s)
  );

  pdn_sync2 u_sync_b (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pg_b),
    .q    (pgb_s)
  );

  always_comb begin
    step     = (scnt == S_LAST);
    scnt_inc = (scnt == S_MAX) ? scnt : scnt + 1'b1;
    tcnt_inc = (tcnt == T_MAX) ? tcnt : tcnt + 1'b1;

    lose = (!pga_s && state inside
             {S_RAMP_A, S_WAIT_PG_B, S_RAMP_B, S_ON})
        || (!pgb_s && state inside {S_RAMP_B, S_ON});

    tmo = (tcnt == T_LAST)
       && ((state == S_WAIT_PG_A && !pga_s)
        || (state == S_WAIT_PG_B && !pgb_s));

    can_down = state inside {S_WAIT_PG_A, S_RAMP_A,
                             S_WAIT_PG_B, S_RAMP_B, S_ON};

    // one descending shutdown step; rails follow their lowest block
    hb     = hi_bit(blk_en);
    dn_blk = blk_en;
    if (blk_en != '0) dn_blk[hb] = 1'b0;
    dn_sub = sup_en_b && (hb > GRP_B_FIRST);
    dn_sua = sup_en_a && (hb > GRP_A_FIRST);
  end

  always_comb begin
    state_d = state;
    blk_d   = blk_en;
    sua_d   = sup_en_a;
    sub_d   = sup_en_b;
    scnt_d  = scnt;
    tcnt_d  = tcnt;

    if (lose || tmo) begin
      state_d = S_FAULT;
      blk_d   = '0;
      sua_d   = 1'b0;
      sub_d   = 1'b0;
    end else if (can_down && !pwr_req) begin
      blk_d   = dn_blk;
      sua_d   = dn_sua;
      sub_d   = dn_sub;
      scnt_d  = '0;
      state_d = dn_sua ? S_RAMP_DOWN : S_OFF;
    end else begin
      unique case (state)
        S_OFF: begin
          if (pwr_req) begin
            state_d = S_WAIT_PG_A;
            sua_d   = 1'b1;
            tcnt_d  = '0;
          end
        end
        S_WAIT_PG_A: begin
          if (pga_s) begin
            state_d            = S_RAMP_A;
            blk_d[GRP_A_FIRST] = 1'b1;
            scnt_d             = '0;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
        S_RAMP_A: begin
          if (step) begin
            scnt_d = '0;
            if (!blk_en[1]) begin
              blk_d[1] = 1'b1;
            end else if (!blk_en[GRP_A_LAST]) begin
              blk_d[GRP_A_LAST] = 1'b1;
            end else begin
              state_d = S_WAIT_PG_B;
              sub_d   = 1'b1;
              tcnt_d  = '0;
            end
          end else begin
            scnt_d = scnt_inc;
          end
        end
        S_WAIT_PG_B: begin
          if (pgb_s) begin
            state_d            = S_RAMP_B;
            blk_d[GRP_B_FIRST] = 1'b1;
            scnt_d             = '0;
          end else begin
            tcnt_d = tcnt_inc;
          end
        end
        S_RAMP_B: begin
          if (step) begin
            scnt_d = '0;
            if (!blk_en[4]) begin
              blk_d[4] = 1'b1;
            end else if (!blk_en[GRP_B_LAST]) begin
              blk_d[GRP_B_LAST] = 1'b1;
            end else begin
              state_d = S_ON;
            end
          end else begin
            scnt_d = scnt_inc;
          end
        end
        S_ON: begin
        end
        S_RAMP_DOWN: begin
          if (step) begin
            blk_d   = dn_blk;
            sua_d   = dn_sua;
            sub_d   = dn_sub;
            scnt_d  = '0;
            state_d = dn_sua ? S_RAMP_DOWN : S_OFF;
          end else begin
            scnt_d = scnt_inc;
          end
        end
        S_FAULT: begin
          if (!pwr_req) state_d = S_OFF;
        end
        default: state_d = S_OFF;
      endcase
    end

    busy_d  = state_d inside {S_WAIT_PG_A, S_RAMP_A,
                              S_WAIT_PG_B, S_RAMP_B,
                              S_RAMP_DOWN};
    done_d  = (state_d == S_ON);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_OFF;
      blk_en    <= '0;
      sup_en_a  <= 1'b0;
      sup_en_b  <= 1'b0;
      scnt      <= '0;
      tcnt      <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      seq_fault <= 1'b0;
    end else begin
      state     <= state_d;
      blk_en    <= blk_d;
      sup_en_a  <= sua_d;
      sup_en_b  <= sub_d;
      scnt      <= scnt_d;
      tcnt      <= tcnt_d;
      seq_busy  <= busy_d;
      seq_done  <= done_d;
      seq_fault <= fault_d;
    end
  end

endmodule
